aes_cipher_core: RTL and testbench

Iterative AES-128 encryption datapath, one round per clock, downstream of the round-key expansion stage. Consumes the eleven expanded round keys and their per-key done flags, accepts one 128-bit plaintext block over a valid/ready handshake, and returns the ciphertext over a second valid/ready handshake. If the round key a round needs is not yet flagged done, the core stalls in place. This lets encryption overlap key expansion.

---
 rtl/aes_pkg.sv | 67 ++++++
 rtl/aes_round.sv | 19 +
 rtl/aes_cipher_core.sv | 116 +++++++++++
 tb/tb_aes_cipher_core.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES-128 shared types, S-box and round-transform helpers.
package aes_pkg;

   typedef logic [127:0] aes_block_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } aes_fsm_e;

   localparam int NR = 10;

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      int idx;
      idx = 255 - int'(x);
      return SBOX[idx*8 +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic aes_block_t sub_bytes(input aes_block_t s);
      aes_block_t o;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
      return o;
   endfunction

   // Byte i lives at [127-8i -: 8]; row r of column c is byte r+4c.
   function automatic aes_block_t shift_rows(input aes_block_t s);
      aes_block_t o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      return o;
   endfunction

   function automatic aes_block_t mix_columns(input aes_block_t s);
      aes_block_t o;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-8*(4*c)   -: 8];
         a1 = s[127-8*(4*c+1) -: 8];
         a2 = s[127-8*(4*c+2) -: 8];
         a3 = s[127-8*(4*c+3) -: 8];
         o[127-8*(4*c)   -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[127-8*(4*c+1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[127-8*(4*c+3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round; final round skips MixColumns.
module aes_round
   import aes_pkg::*;
(
   input  aes_block_t state_i,
   input  aes_block_t round_key_i,
   input  logic       final_i,
   output aes_block_t state_o
);

   aes_block_t sr;

   // SubBytes -> ShiftRows -> (MixColumns) -> AddRoundKey
   always_comb begin
      sr      = shift_rows(sub_bytes(state_i));
      state_o = (final_i ? sr : mix_columns(sr)) ^ round_key_i;
   end

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES-128 encryptor: one round per clock, stalls on missing round keys.
module aes_cipher_core
   import aes_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [0:10][127:0] round_key_i,
   input  logic [0:10]        round_key_done_i,
   input  logic              pt_valid_i,
   output logic              pt_ready_o,
   input  logic [127:0]      pt_i,
   output logic              ct_valid_o,
   input  logic              ct_ready_i,
   output logic [127:0]      ct_o,
   output logic              busy_o,
   output logic [3:0]        round_o
);

   aes_fsm_e   fsm_q, fsm_d;
   aes_block_t state_q, state_d;
   logic [3:0] rnd_q, rnd_d;
   aes_block_t ct_q, ct_d;
   logic       ct_valid_q, ct_valid_d;

   aes_block_t rk_sel, round_out;
   logic       key_ok;

   // Select the key and done flag for the round about to execute.
   always_comb begin
      rk_sel = '0;
      key_ok = 1'b0;
      for (int k = 0; k <= NR; k++) begin
         if (rnd_q == 4'(k)) begin
            rk_sel = round_key_i[k];
            key_ok = round_key_done_i[k];
         end
      end
   end

   aes_round u_round (
      .state_i     (state_q),
      .round_key_i (rk_sel),
      .final_i     (rnd_q == 4'(NR)),
      .state_o     (round_out)
   );

   // Ready is forced low while reset is held, even if key 0 is already done.
   assign pt_ready_o = (fsm_q == IDLE) & round_key_done_i[0] & rst_ni;
   assign ct_valid_o = ct_valid_q;
   assign ct_o       = ct_q;
   assign busy_o     = (fsm_q == ROUND) | (fsm_q == DONE);
   assign round_o    = rnd_q;

   // Next-state and datapath update.
   always_comb begin
      fsm_d      = fsm_q;
      state_d    = state_q;
      rnd_d      = rnd_q;
      ct_d       = ct_q;
      ct_valid_d = ct_valid_q;
      case (fsm_q)
         IDLE: begin
            if (pt_valid_i && pt_ready_o) begin
               state_d = pt_i ^ round_key_i[0];
               rnd_d   = 4'd1;
               fsm_d   = ROUND;
            end
         end
         ROUND: begin
            // A missing key simply freezes state and round counter.
            if (key_ok) begin
               state_d = round_out;
               if (rnd_q == 4'(NR)) begin
                  ct_d       = round_out;
                  ct_valid_d = 1'b1;
                  fsm_d      = DONE;
               end else begin
                  rnd_d = rnd_q + 4'd1;
               end
            end
         end
         DONE: begin
            if (ct_ready_i) begin
               ct_valid_d = 1'b0;
               rnd_d      = 4'd0;
               fsm_d      = IDLE;
            end
         end
         default: begin
            fsm_d      = IDLE;
            state_d    = '0;
            rnd_d      = 4'd0;
            ct_d       = '0;
            ct_valid_d = 1'b0;
         end
      endcase
   end

   // State registers, cleared asynchronously.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fsm_q      <= IDLE;
         state_q    <= '0;
         rnd_q      <= 4'd0;
         ct_q       <= '0;
         ct_valid_q <= 1'b0;
      end else begin
         fsm_q      <= fsm_d;
         state_q    <= state_d;
         rnd_q      <= rnd_d;
         ct_q       <= ct_d;
         ct_valid_q <= ct_valid_d;
      end
   end

endmodule

// File: tb/tb_aes_cipher_core.sv
// Scoreboard bench for aes_cipher_core with an independent AES-128 model.
module tb_aes_cipher_core;

   typedef logic [0:10][127:0] rk_t;

   logic        clk = 1'b0;
   logic        rst_n;
   rk_t         rk;
   logic [0:10] done;
   logic        pt_valid;
   logic        pt_ready;
   logic [127:0] pt;
   logic        ct_valid;
   logic        ct_ready;
   logic [127:0] ct;
   logic        busy;
   logic [3:0]  round;

   aes_cipher_core dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .round_key_i      (rk),
      .round_key_done_i (done),
      .pt_valid_i       (pt_valid),
      .pt_ready_o       (pt_ready),
      .pt_i             (pt),
      .ct_valid_o       (ct_valid),
      .ct_ready_i       (ct_ready),
      .ct_o             (ct),
      .busy_o           (busy),
      .round_o          (round)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int last_acc = 0;
   int hs_cyc = 0;
   bit rand_rdy = 0;
   logic [127:0] exp_q[$];
   logic [7:0] sb [256];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
      n_cmp++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, a, e);
      end
   endtask

   task automatic timeout(input string nm);
      n_cmp++;
      n_err++;
      $display("FAIL %s: timed out", nm);
   endtask

   // ---------------- reference model (plain GF(2^8) arithmetic) ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   // S-box from multiplicative inverse plus affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic rk_t expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      rk_t k;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int n = 0; n < 11; n++) k[n] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
      return k;
   endfunction

   function automatic logic [127:0] ref_enc(input rk_t k, input logic [127:0] p);
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [127:0] o;
      for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ k[0][127-8*i -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) t[w+4*c] = s[w+4*((c+w)%4)];
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
               if (r < 10)
                  s[w+4*c] = gmul(8'h02, t[w+4*c]) ^ gmul(8'h03, t[(w+1)%4+4*c])
                           ^ t[(w+2)%4+4*c] ^ t[(w+3)%4+4*c];
               else
                  s[w+4*c] = t[w+4*c];
         for (int i = 0; i < 16; i++) s[i] ^= k[r][127-8*i -: 8];
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction

   // ---------------- monitor: pop and compare on each ciphertext handshake ----------------
   always @(negedge clk) begin
      logic [127:0] e;
      if (rst_n && ct_valid && ct_ready) begin
         if (exp_q.size() == 0) begin
            timeout("ct_unexpected");
         end else begin
            e = exp_q.pop_front();
            chk("ct", ct, e);
         end
         hs_cyc = cyc;
      end
   end

   // Random backpressure when enabled.
   initial forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) ct_ready = 1'($urandom_range(0, 1));
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [127:0] p, input logic [127:0] e, input bit push);
      bit got = 0;
      pt = p;
      pt_valid = 1'b1;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (pt_ready) begin got = 1; break; end
      end
      if (!got) timeout("accept");
      else if (push) exp_q.push_back(e);
      @(posedge clk);
      #1;
      pt_valid = 1'b0;
      last_acc = cyc;
   endtask

   task automatic wait_valid();
      bit got = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (ct_valid) begin got = 1; break; end
      end
      if (!got) timeout("ct_valid");
   endtask

   task automatic drain();
      bit got = 0;
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0) begin got = 1; break; end
      end
      if (!got) timeout("drain");
      @(posedge clk);
      #1;
   endtask

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

   // ---------------- main sequence ----------------
   initial begin
      logic [127:0] key, p, hold;
      rk_t kk;
      rst_n = 1'b0;
      done = '1;
      pt_valid = 1'b0;
      pt = '0;
      ct_ready = 1'b1;
      build_sbox();
      rk = expand(C1_KEY);

      // Reset: everything low, even with key 0 flagged done.
      @(negedge clk);
      chk("rst_pt_ready", 128'(pt_ready), 128'(0));
      chk("rst_ct_valid", 128'(ct_valid), 128'(0));
      chk("rst_ct", ct, 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_round", 128'(round), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // FIPS-197 C.1 with latency check.
      send(C1_PT, C1_CT, 1);
      wait_valid();
      chk("c1_latency", 128'(cyc - last_acc), 128'(10));
      drain();

      // FIPS-197 B with key flags rising one per 4 cycles.
      rk = expand(B_KEY);
      done = '0;
      done[0] = 1'b1;
      send(B_PT, B_CT, 1);
      fork
         begin
            for (int k = 1; k <= 10; k++) begin
               repeat (4) @(posedge clk);
               #1;
               done[k] = 1'b1;
            end
         end
         begin
            logic [3:0] prev_r = 4'd0;
            bit prev_st = 0;
            for (int n = 0; n < 80 && !ct_valid; n++) begin
               @(negedge clk);
               if (prev_st) chk("stall_hold", 128'(round), 128'(prev_r));
               prev_st = busy && !ct_valid && (round <= 4'd10) && !done[round];
               prev_r = round;
            end
         end
      join
      drain();

      // Backpressure: hold ct_ready low for 20 cycles.
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      p   = {$urandom(), $urandom(), $urandom(), $urandom()};
      kk = expand(key);
      rk = kk;
      ct_ready = 1'b0;
      send(p, ref_enc(kk, p), 1);
      wait_valid();
      hold = ct;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         chk("bp_ct_stable", ct, hold);
         chk("bp_pt_ready", 128'(pt_ready), 128'(0));
      end
      @(posedge clk);
      #1;
      ct_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_idle_busy", 128'(busy), 128'(0));
      chk("bp_idle_pt_ready", 128'(pt_ready), 128'(1));
      chk("bp_idle_round", 128'(round), 128'(0));

      // Key 0 not ready: no accept until its flag rises.
      rk = expand(C1_KEY);
      done = '1;
      done[0] = 1'b0;
      pt = C1_PT;
      pt_valid = 1'b1;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         chk("nokey_pt_ready", 128'(pt_ready), 128'(0));
         chk("nokey_busy", 128'(busy), 128'(0));
      end
      @(posedge clk);
      #1;
      done[0] = 1'b1;
      send(C1_PT, C1_CT, 1);
      chk("nokey_accepted", 128'(busy), 128'(1));
      drain();

      // Reset mid-block at round 5.
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      rk = expand(key);
      send(128'h0, 128'h0, 0);
      begin
         bit got = 0;
         for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (round == 4'd5) begin got = 1; break; end
         end
         if (!got) timeout("reach_round5");
      end
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ct_valid", 128'(ct_valid), 128'(0));
      chk("mid_rst_ct", ct, 128'(0));
      chk("mid_rst_busy", 128'(busy), 128'(0));
      chk("mid_rst_round", 128'(round), 128'(0));
      chk("mid_rst_pt_ready", 128'(pt_ready), 128'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      rk = expand(C1_KEY);
      @(posedge clk);
      #1;
      send(C1_PT, C1_CT, 1);
      drain();

      // Back-to-back: second block accepted one cycle after first handoff.
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      kk = expand(key);
      rk = kk;
      p = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(p, ref_enc(kk, p), 1);
      p = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(p, ref_enc(kk, p), 1);
      chk("b2b_accept_gap", 128'(last_acc), 128'(hs_cyc + 2));
      drain();

      // Random blocks with random backpressure and idle gaps.
      rand_rdy = 1;
      for (int b = 0; b < 12; b++) begin
         key = {$urandom(), $urandom(), $urandom(), $urandom()};
         p   = {$urandom(), $urandom(), $urandom(), $urandom()};
         kk = expand(key);
         rk = kk;
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         send(p, ref_enc(kk, p), 1);
         drain();
      end
      rand_rdy = 0;
      @(posedge clk);
      #2;
      ct_ready = 1'b1;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
